// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-requester round-robin SPI bus arbiter feeding a byte shift engine.
// Optional watchdog on stalled bursts is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       wr_valid0,
   input  logic       wr_valid1,
   input  logic [7:0] wr_data0,
   input  logic [7:0] wr_data1,
   input  logic       wr_last0,
   input  logic       wr_last1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       wr_ready,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       eng_start,
   output logic [7:0] eng_tx,
   input  logic       eng_done,
   input  logic [7:0] eng_rx,
   output logic       chip_select,
   output logic       timeout
);

   typedef enum logic [2:0] {IDLE, SETUP, WAIT_BYTE, XFER, HOLD} state_t;

   state_t state;
   logic   owner;    // 1 when requester 1 holds the bus
   logic   prio1;    // 1 when requester 1 wins a tie
   logic   last_q;
   logic   drop_q;   // granted req fell during XFER; finish the byte, then release

`ifdef SPI_ARB_TIMEOUT_EN
   logic [7:0] wd;
`endif

   logic       g_req;
   logic       g_valid;
   logic [7:0] g_data;
   logic       g_last;
   logic       pick1;

   assign g_req   = owner ? req1      : req0;
   assign g_valid = owner ? wr_valid1 : wr_valid0;
   assign g_data  = owner ? wr_data1  : wr_data0;
   assign g_last  = owner ? wr_last1  : wr_last0;
   assign pick1   = req1 & (~req0 | prio1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         prio1       <= 1'b0;
         last_q      <= 1'b0;
         drop_q      <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         wr_ready    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= 8'h00;
         eng_start   <= 1'b0;
         eng_tx      <= 8'h00;
         chip_select <= 1'b1;
         timeout     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         wd          <= 8'd0;
`endif
      end else begin
         eng_start <= 1'b0;
         rd_valid  <= 1'b0;
         timeout   <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner       <= pick1;
                  prio1       <= ~pick1;
                  gnt0        <= ~pick1;
                  gnt1        <= pick1;
                  chip_select <= 1'b0;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               wr_ready <= 1'b1;
               state    <= WAIT_BYTE;
`ifdef SPI_ARB_TIMEOUT_EN
               wd       <= 8'd0;
`endif
            end
            WAIT_BYTE: begin
               if (!g_req) begin
                  gnt0        <= 1'b0;
                  gnt1        <= 1'b0;
                  chip_select <= 1'b1;
                  wr_ready    <= 1'b0;
                  state       <= HOLD;
               end else if (g_valid) begin
                  eng_start <= 1'b1;
                  eng_tx    <= g_data;
                  last_q    <= g_last;
                  drop_q    <= 1'b0;
                  wr_ready  <= 1'b0;
                  state     <= XFER;
`ifdef SPI_ARB_TIMEOUT_EN
               end else if (wd == 8'd254) begin
                  wd          <= 8'd255;
                  timeout     <= 1'b1;
                  gnt0        <= 1'b0;
                  gnt1        <= 1'b0;
                  chip_select <= 1'b1;
                  wr_ready    <= 1'b0;
                  state       <= HOLD;
               end else begin
                  wd <= wd + 8'd1;
`endif
               end
            end
            XFER: begin
               if (!g_req)
                  drop_q <= 1'b1;
               if (eng_done) begin
                  rd_data  <= eng_rx;
                  rd_valid <= 1'b1;
                  if (last_q | drop_q | ~g_req) begin
                     gnt0        <= 1'b0;
                     gnt1        <= 1'b0;
                     chip_select <= 1'b1;
                     state       <= HOLD;
                  end else begin
                     wr_ready <= 1'b1;
                     state    <= WAIT_BYTE;
`ifdef SPI_ARB_TIMEOUT_EN
                     wd       <= 8'd0;
`endif
                  end
               end
            end
            HOLD: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
